// File: rtl/hazard_seq_ctrl.sv
// rtl/hazard_seq_ctrl.sv - pipeline hazard, branch-flush and memory-wait sequencer
// Registered RUN/MEM_WAIT state; all pipeline controls are combinational from state and inputs.
module hazard_seq_ctrl #(
  parameter bit FWD_DEFAULT = 1'b0,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_two_src,
  input  logic [3:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             fwd_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             freeze_all,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_fwd_active;
  logic             w_exe_hit;
  logic             w_mem_hit;
  logic             w_hazard;
  logic             w_mem_stall;
  logic             w_bubble;

  // Register 0xF is the "no register" encoding, so it never creates a dependency.
  assign w_exe_hit = exe_wb_en && (exe_dest != 4'hF) &&
                     ((exe_dest == id_src1) || (id_two_src && (exe_dest == id_src2)));
  assign w_mem_hit = mem_wb_en && (mem_dest != 4'hF) &&
                     ((mem_dest == id_src1) || (id_two_src && (mem_dest == id_src2)));

  // With forwarding, only a load result in EXE cannot be bypassed in time.
  assign w_fwd_active = fwd_en | FWD_DEFAULT;
  assign w_hazard     = id_valid &&
                        (w_fwd_active ? (w_exe_hit && exe_mem_r_en) : (w_exe_hit || w_mem_hit));

  assign w_mem_stall = mem_req && !mem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    freeze_pc    = 1'b0;
    freeze_if_id = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    freeze_all   = 1'b0;
    w_bubble     = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_RUN: begin
          if (w_mem_stall) begin
            w_next_state = ST_MEM_WAIT;
            freeze_all   = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          // Leaving on ready or on an abandoned request; a new request is judged in RUN.
          if (w_mem_stall) begin
            freeze_all = 1'b1;
          end else begin
            w_next_state = ST_RUN;
          end
        end
        default: w_next_state = ST_RUN;
      endcase
      if (!freeze_all) begin
        if (branch_taken) begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (w_hazard) begin
          freeze_pc    = 1'b1;
          freeze_if_id = 1'b1;
          flush_id_ex  = 1'b1;
          w_bubble     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_bubble && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign state     = r_state;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_seq_ctrl.sv
// tb/tb_hazard_seq_ctrl.sv - self-checking bench for hazard_seq_ctrl
// Directed vectors with literal expectations plus a rule-level model compared every cycle.
module tb_hazard_seq_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [3:0]       id_src1;
  logic [3:0]       id_src2;
  logic             id_two_src;
  logic [3:0]       exe_dest;
  logic             exe_wb_en;
  logic             exe_mem_r_en;
  logic [3:0]       mem_dest;
  logic             mem_wb_en;
  logic             fwd_en;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             freeze_pc;
  logic             freeze_if_id;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             freeze_all;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  bit m_wait = 1'b0;
  int m_cnt  = 0;

  hazard_seq_ctrl #(.FWD_DEFAULT(1'b0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .fwd_en(fwd_en), .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .freeze_pc(freeze_pc), .freeze_if_id(freeze_if_id), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .freeze_all(freeze_all), .state(state), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_hazard();
    bit exe_hit = 1'b0;
    bit mem_hit = 1'b0;
    logic [3:0] s;
    for (int k = 0; k < 2; k++) begin
      s = (k == 0) ? id_src1 : id_src2;
      if ((k == 0 || id_two_src) && s != 4'd15) begin
        if (exe_wb_en && exe_dest == s) exe_hit = 1'b1;
        if (mem_wb_en && mem_dest == s) mem_hit = 1'b1;
      end
    end
    if (!id_valid) return 1'b0;
    return fwd_en ? (exe_hit && exe_mem_r_en) : (exe_hit || mem_hit);
  endfunction

  always @(negedge clk) begin
    bit stall, br, hz;
    stall = !rst && mem_req && !mem_ready;
    br    = !rst && !stall && branch_taken;
    hz    = !rst && !stall && !branch_taken && model_hazard();
    chk("m_freeze_all",   freeze_all,   stall);
    chk("m_flush_if_id",  flush_if_id,  br);
    chk("m_flush_id_ex",  flush_id_ex,  br || hz);
    chk("m_freeze_pc",    freeze_pc,    hz);
    chk("m_freeze_if_id", freeze_if_id, hz);
    chk("m_state",        state,        m_wait ? 32'd1 : 32'd0);
    chk("m_stall_cnt",    stall_cnt,    m_cnt);
    if (rst) begin
      m_wait = 1'b0;
      m_cnt  = 0;
    end else begin
      m_wait = stall;
      if (hz && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end
  end

  task automatic clear_in();
    id_valid = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0;
    exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0;
    mem_dest = 0; mem_wb_en = 0; fwd_en = 0;
    branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic load_use();
    fwd_en = 1; exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 3; id_src1 = 3; id_valid = 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_in();
    rst = 1;
    step();
    load_use(); branch_taken = 1; mem_req = 1;
    #3;
    chk("rst_freeze_all", freeze_all, 0);
    chk("rst_flush_if_id", flush_if_id, 0);
    chk("rst_flush_id_ex", flush_id_ex, 0);
    chk("rst_freeze_pc", freeze_pc, 0);
    step(); clear_in(); rst = 0;
    #3;
    chk("reset_state", state, 0);
    chk("reset_cnt", stall_cnt, 0);

    step(); load_use();
    #3;
    chk("lu_freeze_pc", freeze_pc, 1);
    chk("lu_freeze_if_id", freeze_if_id, 1);
    chk("lu_flush_id_ex", flush_id_ex, 1);
    chk("lu_flush_if_id", flush_if_id, 0);
    chk("lu_cnt_before", stall_cnt, 0);
    step(); clear_in();
    #3;
    chk("lu_cnt_after", stall_cnt, 1);

    step(); id_valid = 1; mem_wb_en = 1; mem_dest = 5; id_two_src = 1; id_src2 = 5; fwd_en = 0;
    #3;
    chk("memhz_nofwd_stall", freeze_pc, 1);
    step(); fwd_en = 1;
    #3;
    chk("memhz_fwd_nostall", freeze_pc, 0);
    chk("memhz_fwd_bubble", flush_id_ex, 0);
    chk("memhz_cnt", stall_cnt, 2);

    step(); clear_in(); load_use(); branch_taken = 1;
    #3;
    chk("br_flush_if_id", flush_if_id, 1);
    chk("br_flush_id_ex", flush_id_ex, 1);
    chk("br_freeze_pc", freeze_pc, 0);
    step(); clear_in();
    #3;
    chk("br_cnt", stall_cnt, 2);

    for (int i = 0; i < 3; i++) begin
      step(); clear_in(); mem_req = 1;
      if (i == 1) branch_taken = 1;
      if (i == 2) load_use();
      #3;
      chk("wait_freeze_all", freeze_all, 1);
      chk("wait_no_flush", flush_if_id, 0);
      chk("wait_no_freeze_pc", freeze_pc, 0);
      chk("wait_state", state, (i == 0) ? 0 : 1);
    end
    step(); clear_in(); mem_req = 1; mem_ready = 1;
    #3;
    chk("ready_freeze_all", freeze_all, 0);
    chk("ready_state", state, 1);
    step(); clear_in();
    #3;
    chk("after_wait_state", state, 0);
    chk("after_wait_cnt", stall_cnt, 2);

    step(); mem_req = 1;
    step(); clear_in();
    #3;
    chk("abandon_state", state, 1);
    chk("abandon_freeze_all", freeze_all, 0);
    step();
    #3;
    chk("abandon_return", state, 0);

    step(); mem_req = 1;
    step(); mem_req = 1;
    step(); mem_req = 1; rst = 1; load_use(); branch_taken = 1;
    #3;
    chk("midwait_rst_state", state, 1);
    chk("midwait_rst_freeze_all", freeze_all, 0);
    chk("midwait_rst_flush", flush_id_ex, 0);
    chk("midwait_rst_freeze_pc", freeze_pc, 0);
    step(); clear_in(); rst = 0;
    #3;
    chk("midwait_post_state", state, 0);
    chk("midwait_post_cnt", stall_cnt, 0);

    step(); id_valid = 1; exe_wb_en = 1; exe_dest = 15; id_src1 = 15;
    #3;
    chk("reg_f_ignored", freeze_pc, 0);
    step(); clear_in(); exe_wb_en = 1; exe_dest = 4; id_src1 = 4;
    #3;
    chk("invalid_id", freeze_pc, 0);
    step(); clear_in(); id_valid = 1; exe_wb_en = 1; exe_dest = 7; id_src2 = 7;
    #3;
    chk("src2_unused", freeze_pc, 0);

    for (int i = 0; i < 80; i++) begin
      step();
      rst = ($urandom_range(0, 29) == 0);
      id_valid = $urandom_range(0, 3) != 0;
      id_src1 = 4'($urandom_range(12, 15));
      id_src2 = 4'($urandom_range(12, 15));
      id_two_src = $urandom_range(0, 1);
      exe_dest = 4'($urandom_range(12, 15));
      exe_wb_en = $urandom_range(0, 1);
      exe_mem_r_en = $urandom_range(0, 1);
      mem_dest = 4'($urandom_range(12, 15));
      mem_wb_en = $urandom_range(0, 1);
      fwd_en = $urandom_range(0, 1);
      branch_taken = ($urandom_range(0, 4) == 0);
      mem_req = ($urandom_range(0, 3) == 0);
      mem_ready = $urandom_range(0, 1);
    end

    step(); clear_in(); rst = 1;
    step(); rst = 0; load_use();
    for (int i = 1; i < 20; i++) begin
      step();
      if (i == 15) chk("sat_reach", stall_cnt, 15);
    end
    step(); clear_in();
    #3;
    chk("sat_hold", stall_cnt, 15);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
